fuel_chain_accum: RTL and testbench

//  Streaming fuel-requirement accumulator: per accepted module mass m, adds

---
 rtl/fuel_chain_accum_if.sv | 27 ++
 rtl/fuel_chain_accum.sv | 110 +++++++++++
 tb/tb_fuel_chain_accum.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fuel_chain_accum_if.sv
// Handshake and result bus of the fuel chain accumulator.
interface fuel_chain_accum_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mass;
  logic             mode_recursive;
  logic             clear;
  logic [WIDTH-1:0] total;
  logic [CNT_W-1:0] module_count;
  logic             busy;
  logic             overflow;

  // Source / consumer side
  modport master (
    output in_valid, in_mass, mode_recursive, clear,
    input  in_ready, total, module_count, busy, overflow
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_mass, mode_recursive, clear,
    output in_ready, total, module_count, busy, overflow
  );
endinterface

// File: rtl/fuel_chain_accum.sv
// Streaming fuel accumulator: adds step(m)=floor(m/3)-2 (or its whole chain
// down to zero) per accepted mass into a running total.
// Optional feature macro FUEL_CHAIN_SAT_EN: total saturates at all-ones on
// carry-out instead of wrapping; overflow is sticky in both builds.
module fuel_chain_accum #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  fuel_chain_accum_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] step_arg;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] step_val;
  logic             step_zero;
  logic             mode_q;
  logic             accept;
  logic             ready_c;
  logic             busy_c;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] total_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  // One shared step unit: new mass while idle, current term while iterating
  always_comb begin
    step_arg  = (state == IDLE) ? bus.in_mass : cur;
    step_q    = step_arg / WIDTH'(3);
    step_val  = (step_q <= WIDTH'(2)) ? '0 : step_q - WIDTH'(2);
    step_zero = (step_val == '0);
  end

  assign accept  = bus.in_valid && ready_c;
  assign sum_ext = {1'b0, total_q} + {1'b0, cur};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: clear aborts a chain; single mode leaves after one add
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !step_zero) state_next = ITER;
      end
      ITER: begin
        if (bus.clear || !mode_q || step_zero) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready_c = 1'b0;
    busy_c  = 1'b0;
    ready_c = (state == IDLE) && !bus.clear && !rst;
    busy_c  = (state == ITER);
  end

  // Datapath: term register, mode latch, total, counter, sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= '0;
      mode_q     <= 1'b0;
      total_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      total_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        cur    <= step_val;
        mode_q <= bus.mode_recursive;
        if (count_q != '1) count_q <= count_q + CNT_W'(1);
      end
      if (state == ITER) begin
        cur        <= step_val;
        overflow_q <= overflow_q | sum_ext[WIDTH];
`ifdef FUEL_CHAIN_SAT_EN
        total_q    <= sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];
`else
        total_q    <= sum_ext[WIDTH-1:0];
`endif
      end
    end
  end

  assign bus.in_ready     = ready_c;
  assign bus.busy         = busy_c;
  assign bus.total        = total_q;
  assign bus.module_count = count_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_fuel_chain_accum.sv
// Self-checking bench for fuel_chain_accum: a 64-bit and an 8-bit instance,
// each shadowed by a term-queue model and compared on every falling edge.
module tb_fuel_chain_accum;

  logic clk = 1'b0;
  logic rst64;
  logic rst8;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fuel_chain_accum_if #(.WIDTH(64), .CNT_W(16)) if64 ();
  fuel_chain_accum_if #(.WIDTH(8),  .CNT_W(16)) if8 ();

  fuel_chain_accum #(.WIDTH(64), .CNT_W(16)) dut64 (.clk(clk), .rst(rst64), .bus(if64.slave));
  fuel_chain_accum #(.WIDTH(8),  .CNT_W(16)) dut8  (.clk(clk), .rst(rst8),  .bus(if8.slave));

  // ---------------- model: per instance, a queue of terms still to add
  logic [63:0] m_tot [2] = '{64'd0, 64'd0};
  logic [15:0] m_cnt [2] = '{16'd0, 16'd0};
  logic        m_ovf [2] = '{1'b0, 1'b0};
  logic [63:0] m_q   [2][0:63];
  int          m_head[2] = '{0, 0};
  int          m_tail[2] = '{0, 0};

  function automatic logic [63:0] fuel(input logic [63:0] x);
    logic [63:0] q;
    q = x / 64'd3;
    return (q <= 64'd2) ? 64'd0 : q - 64'd2;
  endfunction

  task automatic model_tick(input int k, input logic r, input logic v, input logic mr,
                            input logic cl, input logic [63:0] mass, input int w);
    logic [63:0] mask;
    logic [64:0] s;
    logic [63:0] t;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    if (r) begin
      m_tot[k] = '0; m_cnt[k] = '0; m_ovf[k] = 1'b0; m_head[k] = 0; m_tail[k] = 0;
    end else if (cl) begin
      m_tot[k] = '0; m_cnt[k] = '0; m_ovf[k] = 1'b0; m_head[k] = 0; m_tail[k] = 0;
    end else if (m_head[k] != m_tail[k]) begin
      t = m_q[k][m_head[k]];
      m_head[k] = m_head[k] + 1;
      s = {1'b0, m_tot[k]} + {1'b0, t};
      if (s > {1'b0, mask}) begin
        m_ovf[k] = 1'b1;
`ifdef FUEL_CHAIN_SAT_EN
        m_tot[k] = mask;
`else
        m_tot[k] = s[63:0] & mask;
`endif
      end else begin
        m_tot[k] = s[63:0];
      end
    end else if (v) begin
      if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
      m_head[k] = 0; m_tail[k] = 0;
      t = fuel(mass & mask);
      while (t != 0 && m_tail[k] < 64) begin
        m_q[k][m_tail[k]] = t;
        m_tail[k] = m_tail[k] + 1;
        t = mr ? fuel(t) : 64'd0;
      end
    end
  endtask

  // Model advances on the same events as each DUT's registers
  always @(posedge clk or posedge rst64)
    model_tick(0, rst64, if64.in_valid, if64.mode_recursive, if64.clear, if64.in_mass, 64);
  always @(posedge clk or posedge rst8)
    model_tick(1, rst8, if8.in_valid, if8.mode_recursive, if8.clear, 64'(if8.in_mass), 8);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: all outputs of both instances against the model
  always @(negedge clk) begin
    check("rdy64",   64'(if64.in_ready),     64'(!rst64 && !if64.clear && m_head[0] == m_tail[0]));
    check("busy64",  64'(if64.busy),         64'(m_head[0] != m_tail[0]));
    check("total64", if64.total,             m_tot[0]);
    check("cnt64",   64'(if64.module_count), 64'(m_cnt[0]));
    check("ovf64",   64'(if64.overflow),     64'(m_ovf[0]));
    check("rdy8",    64'(if8.in_ready),      64'(!rst8 && !if8.clear && m_head[1] == m_tail[1]));
    check("busy8",   64'(if8.busy),          64'(m_head[1] != m_tail[1]));
    check("total8",  64'(if8.total),         m_tot[1]);
    check("cnt8",    64'(if8.module_count),  64'(m_cnt[1]));
    check("ovf8",    64'(if8.overflow),      64'(m_ovf[1]));
  end

  // ---------------- stimulus helpers
  function automatic logic rdy(input int k);
    return (k == 0) ? if64.in_ready : if8.in_ready;
  endfunction

  task automatic drive(input int k, input logic v, input logic [63:0] m, input logic mr);
    if (k == 0) begin
      if64.in_valid = v; if64.in_mass = m; if64.mode_recursive = mr;
    end else begin
      if8.in_valid = v; if8.in_mass = m[7:0]; if8.mode_recursive = mr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one mass, returns the number of cycles before in_ready returns
  task automatic send(input int k, input logic [63:0] m, input logic mr, output int nbusy);
    int n;
    n = 0;
    while (!rdy(k) && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL send_wait: in_ready stuck low, got 0 expected 1");
    end
    drive(k, 1'b1, m, mr);
    tick();
    drive(k, 1'b0, 64'd0, 1'b0);
    nbusy = 0;
    while (!rdy(k) && nbusy < 200) begin tick(); nbusy++; end
  endtask

  task automatic pulse_clear(input int k);
    if (k == 0) if64.clear = 1'b1; else if8.clear = 1'b1;
    tick();
    if (k == 0) if64.clear = 1'b0; else if8.clear = 1'b0;
    #1;
  endtask

  int nb;

  initial begin
    rst64 = 1'b1; rst8 = 1'b1;
    drive(0, 1'b0, 64'd0, 1'b0);
    drive(1, 1'b0, 64'd0, 1'b0);
    if64.clear = 1'b0; if8.clear = 1'b0;
    tick(); tick();
    check("rst_ready_low", 64'(if64.in_ready), 64'd0);
    rst64 = 1'b0; rst8 = 1'b0;
    #1;
    check("rst_total", if64.total, 64'd0);
    check("post_rst_ready", 64'(if64.in_ready), 64'd1);

    // Single mode: each mass yields one busy cycle
    send(0, 64'd12, 1'b0, nb);     check("t1_gap12", 64'(nb), 64'd1);
    send(0, 64'd14, 1'b0, nb);     check("t1_gap14", 64'(nb), 64'd1);
    send(0, 64'd1969, 1'b0, nb);   check("t1_gap1969", 64'(nb), 64'd1);
    send(0, 64'd100756, 1'b0, nb); check("t1_gap100756", 64'(nb), 64'd1);
    check("t1_total", if64.total, 64'd34241);
    check("t1_model", m_tot[0], 64'd34241);
    check("t1_count", 64'(if64.module_count), 64'd4);

    // Recursive chains
    pulse_clear(0);
    send(0, 64'd1969, 1'b1, nb);
    check("t2_busy1969", 64'(nb), 64'd5);
    check("t2_total966", if64.total, 64'd966);
    send(0, 64'd100756, 1'b1, nb);
    check("t2_busy100756", 64'(nb), 64'd9);
    check("t2_total", if64.total, 64'd51312);
    check("t2_model", m_tot[0], 64'd51312);

    // Zero-term masses: immediately ready again
    pulse_clear(0);
    send(0, 64'd0, 1'b1, nb); check("t3_gap0", 64'(nb), 64'd0);
    send(0, 64'd2, 1'b1, nb); check("t3_gap2", 64'(nb), 64'd0);
    send(0, 64'd8, 1'b1, nb); check("t3_gap8", 64'(nb), 64'd0);
    check("t3_total", if64.total, 64'd0);
    check("t3_count", 64'(if64.module_count), 64'd3);

    // 8-bit instance overflow
    send(1, 64'd255, 1'b1, nb);
    check("t4_busy", 64'(nb), 64'd3);
    check("t4_total1", 64'(if8.total), 64'd114);
    send(1, 64'd255, 1'b1, nb);
    check("t4_total2", 64'(if8.total), 64'd228);
    check("t4_ovf_before", 64'(if8.overflow), 64'd0);
    send(1, 64'd255, 1'b1, nb);
`ifdef FUEL_CHAIN_SAT_EN
    check("t4_total3", 64'(if8.total), 64'd255);
`else
    check("t4_total3", 64'(if8.total), 64'd86);
`endif
    check("t4_ovf", 64'(if8.overflow), 64'd1);
    check("t4_count", 64'(if8.module_count), 64'd3);

    // Reset on the third busy cycle of a chain
    pulse_clear(0);
    drive(0, 1'b1, 64'd1969, 1'b1);
    tick();
    drive(0, 1'b0, 64'd0, 1'b0);
    tick(); tick();
    check("t5_busy3", 64'(if64.busy), 64'd1);
    rst64 = 1'b1;
    #1;
    check("t5_ready", 64'(if64.in_ready), 64'd0);
    check("t5_busy", 64'(if64.busy), 64'd0);
    check("t5_total", if64.total, 64'd0);
    check("t5_count", 64'(if64.module_count), 64'd0);
    check("t5_ovf", 64'(if64.overflow), 64'd0);
    @(posedge clk); #1;
    rst64 = 1'b0;
    #1;
    send(0, 64'd14, 1'b1, nb);
    check("t5_total14", if64.total, 64'd2);
    check("t5_count14", 64'(if64.module_count), 64'd1);

    // Clear on the second busy cycle of a chain
    pulse_clear(0);
    drive(0, 1'b1, 64'd1969, 1'b1);
    tick();
    drive(0, 1'b0, 64'd0, 1'b0);
    tick();
    check("t6_total_pre", if64.total, 64'd654);
    if64.clear = 1'b1;
    #1;
    check("t6_ready_clr", 64'(if64.in_ready), 64'd0);
    tick();
    check("t6_total", if64.total, 64'd0);
    check("t6_count", 64'(if64.module_count), 64'd0);
    check("t6_busy", 64'(if64.busy), 64'd0);
    check("t6_ready_hold", 64'(if64.in_ready), 64'd0);
    if64.clear = 1'b0;
    #1;
    check("t6_ready_after", 64'(if64.in_ready), 64'd1);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
